// File: rtl/stream_packet_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : stream_packet_arbiter
// Description : Packet-locked 2:1 AXI-Stream arbiter, port 0 priority with a
//               starvation limit for port 1, one registered output stage.
// Revision    : 1.0 - initial release
// ============================================================================
module stream_packet_arbiter #(
    parameter int DATA_W       = 64,
    parameter int STARVE_LIMIT = 4
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic [DATA_W-1:0] i_s_axis0_tdata,
    input  logic              i_s_axis0_tvalid,
    input  logic              i_s_axis0_tlast,
    output logic              o_s_axis0_tready,
    input  logic [DATA_W-1:0] i_s_axis1_tdata,
    input  logic              i_s_axis1_tvalid,
    input  logic              i_s_axis1_tlast,
    output logic              o_s_axis1_tready,
    output logic [DATA_W-1:0] o_m_axis_tdata,
    output logic              o_m_axis_tvalid,
    output logic              o_m_axis_tlast,
    input  logic              i_m_axis_tready,
    output logic [1:0]        o_grant,
    output logic [3:0]        o_starve_cnt
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PKT0 = 2'd1,
        PKT1 = 2'd2
    } state_t;

    localparam logic [3:0] c_STARVE_LIMIT = 4'(STARVE_LIMIT);

    state_t            r_state;
    state_t            w_state_nxt;
    logic [DATA_W-1:0] r_m_tdata;
    logic              r_m_tvalid;
    logic              r_m_tlast;
    logic [3:0]        r_starve_cnt;

    logic              w_adv;
    logic              w_sel;
    logic              w_rdy0;
    logic              w_rdy1;
    logic              w_xfer;
    logic              w_xfer_last;
    logic [1:0]        w_grant;

    assign w_adv = !r_m_tvalid || i_m_axis_tready;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_sel       = 1'b0;
        w_grant     = 2'b00;
        w_state_nxt = r_state;
        case (r_state)
            IDLE: w_sel = i_s_axis1_tvalid &&
                          (!i_s_axis0_tvalid || (r_starve_cnt >= c_STARVE_LIMIT));
            PKT0: begin
                w_sel   = 1'b0;
                w_grant = 2'b01;
            end
            PKT1: begin
                w_sel   = 1'b1;
                w_grant = 2'b10;
            end
            default: w_state_nxt = IDLE;
        endcase

        // Readies are forced low while reset is held so no beat is consumed.
        w_rdy0      = i_rst_n && w_adv && !w_sel;
        w_rdy1      = i_rst_n && w_adv && w_sel;
        w_xfer      = (w_rdy0 && i_s_axis0_tvalid) || (w_rdy1 && i_s_axis1_tvalid);
        w_xfer_last = w_sel ? i_s_axis1_tlast : i_s_axis0_tlast;

        if (w_xfer) begin
            if (w_xfer_last) begin
                w_state_nxt = IDLE;
            end else begin
                w_state_nxt = w_sel ? PKT1 : PKT0;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_m_tdata  <= '0;
            r_m_tvalid <= 1'b0;
            r_m_tlast  <= 1'b0;
        end else if (w_xfer) begin
            r_m_tdata  <= w_sel ? i_s_axis1_tdata : i_s_axis0_tdata;
            r_m_tlast  <= w_xfer_last;
            r_m_tvalid <= 1'b1;
        end else if (w_adv) begin
            r_m_tvalid <= 1'b0;
        end
    end

    // Counts port-0 packets that finish while port 1 is waiting.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_starve_cnt <= 4'd0;
        end else if (w_xfer && w_xfer_last) begin
            if (w_sel || !i_s_axis1_tvalid) begin
                r_starve_cnt <= 4'd0;
            end else if (r_starve_cnt < c_STARVE_LIMIT) begin
                r_starve_cnt <= r_starve_cnt + 4'd1;
            end
        end
    end

    assign o_s_axis0_tready = w_rdy0;
    assign o_s_axis1_tready = w_rdy1;
    assign o_m_axis_tdata   = r_m_tdata;
    assign o_m_axis_tvalid  = r_m_tvalid;
    assign o_m_axis_tlast   = r_m_tlast;
    assign o_grant          = w_grant;
    assign o_starve_cnt     = r_starve_cnt;

endmodule
`default_nettype wire

// File: tb/tb_stream_packet_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_stream_packet_arbiter
// Description : Directed and randomized bench for stream_packet_arbiter
//               against a cycle-level behavioural model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_stream_packet_arbiter;

    localparam int DATA_W = 64;
    localparam int LIMIT  = 4;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [DATA_W-1:0] d0, d1;
    logic              v0, v1, l0, l1, mr;

    logic              o_s_axis0_tready, o_s_axis1_tready;
    logic [DATA_W-1:0] o_m_axis_tdata;
    logic              o_m_axis_tvalid, o_m_axis_tlast;
    logic [1:0]        o_grant;
    logic [3:0]        o_starve_cnt;

    int total = 0;
    int bad   = 0;

    // Reference model: locked port (-1 = none), counter, output register.
    int          m_lock = -1;
    int          m_cnt  = 0;
    bit          m_val  = 1'b0;
    logic [63:0] m_data = '0;
    bit          m_last = 1'b0;
    bit          x0, x1;
    int          seq0 = 0, seq1 = 0;

    stream_packet_arbiter #(
        .DATA_W       (DATA_W),
        .STARVE_LIMIT (LIMIT)
    ) u_dut (
        .i_clk            (clk),
        .i_rst_n          (rst_n),
        .i_s_axis0_tdata  (d0),
        .i_s_axis0_tvalid (v0),
        .i_s_axis0_tlast  (l0),
        .o_s_axis0_tready (o_s_axis0_tready),
        .i_s_axis1_tdata  (d1),
        .i_s_axis1_tvalid (v1),
        .i_s_axis1_tlast  (l1),
        .o_s_axis1_tready (o_s_axis1_tready),
        .o_m_axis_tdata   (o_m_axis_tdata),
        .o_m_axis_tvalid  (o_m_axis_tvalid),
        .o_m_axis_tlast   (o_m_axis_tlast),
        .i_m_axis_tready  (mr),
        .o_grant          (o_grant),
        .o_starve_cnt     (o_starve_cnt)
    );

    always #5 clk = ~clk;

    task automatic check_value(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Compare DUT against the model for the current cycle, advance the model
    // across the next rising edge, and return at the following falling edge.
    task automatic step();
        int sel;
        bit adv, r0, r1;
        #1;
        adv = !m_val || mr;
        if (m_lock < 0) sel = (v1 && (!v0 || m_cnt >= LIMIT)) ? 1 : 0;
        else            sel = m_lock;
        r0 = rst_n && adv && (sel == 0);
        r1 = rst_n && adv && (sel == 1);
        check_value("rdy0",  64'(o_s_axis0_tready), 64'(r0));
        check_value("rdy1",  64'(o_s_axis1_tready), 64'(r1));
        check_value("grant", 64'(o_grant), (m_lock < 0) ? 64'd0 : ((m_lock == 0) ? 64'd1 : 64'd2));
        check_value("cnt",   64'(o_starve_cnt), 64'(m_cnt));
        check_value("valid", 64'(o_m_axis_tvalid), 64'(m_val));
        check_value("data",  o_m_axis_tdata, m_data);
        check_value("last",  64'(o_m_axis_tlast), 64'(m_last));
        x0 = r0 && v0;
        x1 = r1 && v1;
        if (!rst_n) begin
            m_lock = -1; m_cnt = 0; m_val = 0; m_data = '0; m_last = 0;
        end else if (x0 || x1) begin
            m_val  = 1;
            m_data = (sel == 1) ? d1 : d0;
            m_last = (sel == 1) ? l1 : l0;
            if (m_last) begin
                m_lock = -1;
                if (sel == 1 || !v1) m_cnt = 0;
                else if (m_cnt < LIMIT) m_cnt = m_cnt + 1;
            end else begin
                m_lock = sel;
            end
        end else if (adv) begin
            m_val = 0;
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        int exp_cnt[5];
        exp_cnt = '{1, 2, 3, 4, 0};

        // Reset with both sources presenting data
        rst_n = 0; mr = 1;
        v0 = 1; d0 = 64'h1; l0 = 1;
        v1 = 1; d1 = 64'h2; l1 = 1;
        @(posedge clk);
        @(negedge clk);
        step();
        step();
        #1;
        check_value("rst_valid", 64'(o_m_axis_tvalid), 64'd0);
        check_value("rst_data",  o_m_axis_tdata, 64'd0);
        check_value("rst_grant", 64'(o_grant), 64'd0);
        check_value("rst_rdy0",  64'(o_s_axis0_tready), 64'd0);
        check_value("rst_rdy1",  64'(o_s_axis1_tready), 64'd0);

        // Simultaneous single-beat packets
        rst_n = 1;
        d0 = 64'hA; d1 = 64'hB;
        step();
        v0 = 0;
        check_value("sim_first", o_m_axis_tdata, 64'hA);
        check_value("sim_cnt1",  64'(o_starve_cnt), 64'd1);
        step();
        v1 = 0;
        check_value("sim_second", o_m_axis_tdata, 64'hB);
        check_value("sim_cnt0",   64'(o_starve_cnt), 64'd0);

        // Packet lock: port 1 three beats, port 0 arrives mid-packet
        v1 = 1; d1 = 64'h10; l1 = 0;
        step();
        check_value("lock_d10",   o_m_axis_tdata, 64'h10);
        check_value("lock_grant", 64'(o_grant), 64'd2);
        d1 = 64'h11; v0 = 1; d0 = 64'h20; l0 = 0;
        #1;
        check_value("lock_rdy0_b2", 64'(o_s_axis0_tready), 64'd0);
        step();
        check_value("lock_d11", o_m_axis_tdata, 64'h11);
        d1 = 64'h12; l1 = 1;
        #1;
        check_value("lock_rdy0_b3", 64'(o_s_axis0_tready), 64'd0);
        step();
        check_value("lock_d12", o_m_axis_tdata, 64'h12);
        v1 = 0;
        step();
        check_value("lock_d20",    o_m_axis_tdata, 64'h20);
        check_value("lock_grant0", 64'(o_grant), 64'd1);
        d0 = 64'h21; l0 = 1;
        step();
        v0 = 0;
        check_value("lock_d21", o_m_axis_tdata, 64'h21);

        // Starvation: continuous port-0 packets, port 1 waiting
        v0 = 1; d0 = 64'h100; l0 = 1;
        v1 = 1; d1 = 64'hEE;  l1 = 1;
        for (int k = 0; k < 5; k++) begin
            step();
            if (x0) d0 = d0 + 64'd1;
            check_value("starve_data", o_m_axis_tdata, (k < 4) ? 64'(64'h100 + k) : 64'hEE);
            check_value("starve_cnt",  64'(o_starve_cnt), 64'(exp_cnt[k]));
        end
        v0 = 0; v1 = 0;

        // Backpressure holds the output register
        v0 = 1; d0 = 64'h55; l0 = 1;
        step();
        v0 = 0;
        v1 = 1; d1 = 64'h66; l1 = 1; mr = 0;
        for (int k = 0; k < 3; k++) begin
            #1;
            check_value("bp_data", o_m_axis_tdata, 64'h55);
            check_value("bp_last", 64'(o_m_axis_tlast), 64'd1);
            check_value("bp_rdy0", 64'(o_s_axis0_tready), 64'd0);
            check_value("bp_rdy1", 64'(o_s_axis1_tready), 64'd0);
            step();
        end
        mr = 1;
        step();
        v1 = 0;
        check_value("bp_release", o_m_axis_tdata, 64'h66);

        // Reset in the middle of a port-0 packet
        v0 = 1; d0 = 64'h30; l0 = 0;
        step();
        d0 = 64'h31;
        step();
        d0 = 64'h32; rst_n = 0;
        step();
        check_value("mid_rst_valid", 64'(o_m_axis_tvalid), 64'd0);
        check_value("mid_rst_grant", 64'(o_grant), 64'd0);
        rst_n = 1; v0 = 0;
        v1 = 1; d1 = 64'h40; l1 = 1;
        step();
        v1 = 0;
        check_value("mid_rst_s1",    o_m_axis_tdata, 64'h40);
        check_value("mid_rst_valid1", 64'(o_m_axis_tvalid), 64'd1);

        // Randomized traffic with random downstream stalls
        x0 = 0; x1 = 0;
        for (int c = 0; c < 3000; c++) begin
            if (x0) v0 = 0;
            if (x1) v1 = 0;
            if (!v0 && $urandom_range(0, 3) != 0) begin
                v0 = 1; d0 = 64'(seq0); seq0++;
                l0 = ($urandom_range(0, 2) == 0);
            end
            if (!v1 && $urandom_range(0, 3) != 0) begin
                v1 = 1; d1 = 64'h1_0000_0000 | 64'(seq1); seq1++;
                l1 = ($urandom_range(0, 2) == 0);
            end
            mr = ($urandom_range(0, 3) != 0);
            step();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
